// File: rtl/riscv_data_memory.sv
// riscv_data_memory: word-organised data memory for the RISC-V load/store path.
// Byte/half/word loads (sign- or zero-extended) and byte-lane masked stores,
// selected by funct3, behind a one-outstanding valid/ready request/response
// handshake with WAIT_STATES extra cycles before each access.
// Optional build macro DMEM_BOUNDS_CHECK_EN: when defined, byte addresses at or
// beyond DEPTH_WORDS*4 return an error; when undefined they wrap modulo the depth.
module riscv_data_memory #(
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_WIDTH  = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   // Count value at which the final wait cycle is reached.
   localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t                r_state;
   logic                  r_req_ready;
   logic                  r_resp_valid;
   logic [31:0]           r_resp_rdata;
   logic                  r_resp_err;
   logic [3:0]            r_wait_cnt;

   // Latched request
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_we;
   logic [2:0]            r_funct3;
   logic [31:0]           r_wdata;

   // Storage and its registered read port
   logic [31:0]           r_mem [DEPTH_WORDS];
   logic [31:0]           r_mem_q;

   logic [IDX_W-1:0]      w_rd_idx;
   logic [IDX_W-1:0]      w_wr_idx;
   logic                  w_accept;
   logic                  w_bad_code;
   logic                  w_misalign;
   logic                  w_oob;
   logic                  w_err;
   logic [3:0]            w_be;
   logic [31:0]           w_wword;
   logic                  w_mem_we;
   logic [31:0]           w_lane_word;
   logic [31:0]           w_load_data;

   assign w_accept = req_valid && r_req_ready;

   // The read address follows the incoming request while idle so that the word
   // is already in r_mem_q by the ACCESS cycle, even with zero wait states.
   assign w_rd_idx = (r_state == S_IDLE) ? req_addr[IDX_W+1:2] : r_addr[IDX_W+1:2];
   assign w_wr_idx = r_addr[IDX_W+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
   assign w_oob = |(r_addr >> (IDX_W + 2));
`else
   // Upper address bits are deliberately ignored so accesses wrap.
   logic w_unused_addr_hi;
   assign w_unused_addr_hi = |(r_addr >> (IDX_W + 2));
   assign w_oob = 1'b0;
`endif

   // Classify the latched funct3 / alignment into illegal-code and misaligned errors
   always_comb begin
      w_bad_code = 1'b0;
      w_misalign = 1'b0;
      case (r_funct3)
         3'b000:  ;
         3'b001:  w_misalign = r_addr[0];
         3'b010:  w_misalign = |r_addr[1:0];
         3'b100:  w_bad_code = r_we;
         3'b101: begin
            w_bad_code = r_we;
            w_misalign = r_addr[0];
         end
         default: w_bad_code = 1'b1;
      endcase
   end

   assign w_err = w_bad_code | w_misalign | w_oob;

   // Replicate store data across lanes and pick the byte enables for the size
   always_comb begin
      w_be    = 4'b1111;
      w_wword = r_wdata;
      case (r_funct3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << r_addr[1:0];
            w_wword = {4{r_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wword = {2{r_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // A store commits only on a clean ACCESS exit edge
   assign w_mem_we = (r_state == S_ACCESS) && !rst && r_we && !w_err;

   // Byte-lane masked write into storage
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (w_mem_we && w_be[i]) begin
            r_mem[w_wr_idx][8*i +: 8] <= w_wword[8*i +: 8];
         end
      end
   end

   // Registered read port
   always_ff @(posedge clk) begin
      r_mem_q <= r_mem[w_rd_idx];
   end

   // Bring the addressed byte/half down to bit 0 and extend it
   assign w_lane_word = r_mem_q >> {r_addr[1:0], 3'b000};

   always_comb begin
      w_load_data = 32'h0;
      case (r_funct3)
         3'b000:  w_load_data = {{24{w_lane_word[7]}}, w_lane_word[7:0]};
         3'b001:  w_load_data = {{16{w_lane_word[15]}}, w_lane_word[15:0]};
         3'b010:  w_load_data = r_mem_q;
         3'b100:  w_load_data = {24'h0, w_lane_word[7:0]};
         3'b101:  w_load_data = {16'h0, w_lane_word[15:0]};
         default: w_load_data = 32'h0;
      endcase
   end

   // Request/response control FSM with registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'h0;
         r_resp_err   <= 1'b0;
         r_wait_cnt   <= 4'd0;
         r_addr       <= '0;
         r_we         <= 1'b0;
         r_funct3     <= 3'b000;
         r_wdata      <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_addr      <= req_addr;
                  r_we        <= req_we;
                  r_funct3    <= req_funct3;
                  r_wdata     <= req_wdata;
                  r_req_ready <= 1'b0;
                  r_wait_cnt  <= 4'd0;
                  r_state     <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
               end
            end
            S_WAIT: begin
               if (r_wait_cnt == WS_LAST) begin
                  r_wait_cnt <= 4'd0;
                  r_state    <= S_ACCESS;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 4'd1;
               end
            end
            S_ACCESS: begin
               r_resp_rdata <= (r_we || w_err) ? 32'h0 : w_load_data;
               r_resp_err   <= w_err;
               r_resp_valid <= 1'b1;
               r_state      <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_req_ready  <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_riscv_data_memory.sv
// Testbench for riscv_data_memory: two instances (0 and 3 wait states) driven
// through a request task; expected responses are queued when a request is
// driven and compared when the response appears.
module tb_riscv_data_memory;

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;

`ifdef DMEM_BOUNDS_CHECK_EN
   localparam bit BOUNDS_ON = 1'b1;
`else
   localparam bit BOUNDS_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0][31:0] req_addr;
   logic [1:0]       req_we;
   logic [1:0][2:0]  req_funct3;
   logic [1:0][31:0] req_wdata;
   logic [1:0]       resp_valid;
   logic [1:0]       resp_ready;
   logic [1:0][31:0] resp_rdata;
   logic [1:0]       resp_err;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      riscv_data_memory #(
         .DEPTH_WORDS (256),
         .ADDR_WIDTH  (32),
         .WAIT_STATES (gi * 3)
      ) dut (
         .clk        (clk),
         .rst        (rst),
         .req_valid  (req_valid[gi]),
         .req_ready  (req_ready[gi]),
         .req_addr   (req_addr[gi]),
         .req_we     (req_we[gi]),
         .req_funct3 (req_funct3[gi]),
         .req_wdata  (req_wdata[gi]),
         .resp_valid (resp_valid[gi]),
         .resp_ready (resp_ready[gi]),
         .resp_rdata (resp_rdata[gi]),
         .resp_err   (resp_err[gi])
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // One complete transaction on instance d; called and returns at a negedge.
   task automatic txn(input int d, input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int hold);
      int   n;
      int   cyc;
      int   ws;
      exp_t e;
      ws = (d == 0) ? 0 : 3;
      sb_q.push_back({exp_rdata, exp_err});
      req_valid[d]  = 1'b1;
      req_we[d]     = we;
      req_funct3[d] = f3;
      req_addr[d]   = addr;
      req_wdata[d]  = wdata;
      n = 0;
      while (!req_ready[d] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready[d]) begin
         check({tag, "_accept_timeout"}, 32'(req_ready[d]), 32'd1);
         req_valid[d] = 1'b0;
         void'(sb_q.pop_front());
         return;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid[d] = 1'b0;
      cyc = 1;
      while (!resp_valid[d] && cyc < 40) begin
         check({tag, "_busy_ready"}, 32'(req_ready[d]), 32'd0);
         @(negedge clk);
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'(ws + 2));
      if (resp_valid[d]) begin
         for (int h = 0; h < hold; h++) begin
            check({tag, "_hold_valid"}, 32'(resp_valid[d]), 32'd1);
            check({tag, "_hold_rdata"}, resp_rdata[d], sb_q[0].rdata);
            check({tag, "_hold_err"}, 32'(resp_err[d]), 32'(sb_q[0].err));
            check({tag, "_hold_ready"}, 32'(req_ready[d]), 32'd0);
            @(negedge clk);
         end
      end
      e = sb_q.pop_front();
      resp_ready[d] = 1'b1;
      check({tag, "_rdata"}, resp_rdata[d], e.rdata);
      check({tag, "_err"}, 32'(resp_err[d]), 32'(e.err));
      $display("txn dut%0d %s we=%0d f3=%0d addr=%08h rdata=%08h err=%0d lat=%0d",
               d, tag, we, f3, addr, resp_rdata[d], resp_err[d], cyc);
      @(posedge clk);
      @(negedge clk);
      resp_ready[d] = 1'b0;
      check({tag, "_done_valid"}, 32'(resp_valid[d]), 32'd0);
      check({tag, "_done_ready"}, 32'(req_ready[d]), 32'd1);
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = '0;
      req_we     = '0;
      req_funct3 = '0;
      req_addr   = '0;
      req_wdata  = '0;
      resp_ready = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("rst_req_ready", 32'(req_ready[d]), 32'd1);
         check("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
         check("rst_rdata", resp_rdata[d], 32'h0);
         check("rst_err", 32'(resp_err[d]), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      // Zero wait states: basic word, sub-word and extension behaviour
      txn(0, "sw0",      1'b1, F_W,  32'h0, 32'hDEADBEEF, 32'h0,        1'b0, 0);
      txn(0, "lw0",      1'b0, F_W,  32'h0, 32'h0,        32'hDEADBEEF, 1'b0, 0);
      txn(0, "sw4",      1'b1, F_W,  32'h4, 32'h12345678, 32'h0,        1'b0, 0);
      txn(0, "sb5",      1'b1, F_B,  32'h5, 32'hABCDEF80, 32'h0,        1'b0, 0);
      txn(0, "lw4",      1'b0, F_W,  32'h4, 32'h0,        32'h12348078, 1'b0, 0);
      txn(0, "lb5",      1'b0, F_B,  32'h5, 32'h0,        32'hFFFFFF80, 1'b0, 0);
      txn(0, "lbu5",     1'b0, F_BU, 32'h5, 32'h0,        32'h00000080, 1'b0, 0);
      txn(0, "lhu4",     1'b0, F_HU, 32'h4, 32'h0,        32'h00008078, 1'b0, 0);
      txn(0, "lh4",      1'b0, F_H,  32'h4, 32'h0,        32'hFFFF8078, 1'b0, 0);
      txn(0, "lh6",      1'b0, F_H,  32'h6, 32'h0,        32'h00001234, 1'b0, 0);
      txn(0, "lb7",      1'b0, F_B,  32'h7, 32'h0,        32'h00000012, 1'b0, 0);

      // Misaligned and illegal accesses
      txn(0, "lh3_mis",  1'b0, F_H,  32'h3, 32'h0,        32'h0,        1'b1, 0);
      txn(0, "sw6_mis",  1'b1, F_W,  32'h6, 32'hFFFFFFFF, 32'h0,        1'b1, 0);
      txn(0, "lw2_mis",  1'b0, F_W,  32'h2, 32'h0,        32'h0,        1'b1, 0);
      txn(0, "lhu5_mis", 1'b0, F_HU, 32'h5, 32'h0,        32'h0,        1'b1, 0);
      txn(0, "ld_f011",  1'b0, 3'b011, 32'h4, 32'h0,      32'h0,        1'b1, 0);
      txn(0, "ld_f110",  1'b0, 3'b110, 32'h4, 32'h0,      32'h0,        1'b1, 0);
      txn(0, "st_f100",  1'b1, 3'b100, 32'h4, 32'h0,      32'h0,        1'b1, 0);
      txn(0, "lw4_kept", 1'b0, F_W,  32'h4, 32'h0,        32'h12348078, 1'b0, 0);
      txn(0, "sh6",      1'b1, F_H,  32'h6, 32'h1234BEEF, 32'h0,        1'b0, 0);
      txn(0, "lw4_sh",   1'b0, F_W,  32'h4, 32'h0,        32'hBEEF8078, 1'b0, 0);

      // Out-of-range address: error with bounds checking, wrap without
      txn(0, "sw400",    1'b1, F_W,  32'h400, 32'h00000055, 32'h0,      BOUNDS_ON, 0);
      txn(0, "lw0_wrap", 1'b0, F_W,  32'h0, 32'h0,
          BOUNDS_ON ? 32'hDEADBEEF : 32'h00000055, 1'b0, 0);

      // Three wait states with a stalled consumer
      txn(1, "w_sw8",    1'b1, F_W,  32'h8, 32'h11111111, 32'h0,        1'b0, 0);
      txn(1, "w_lw8",    1'b0, F_W,  32'h8, 32'h0,        32'h11111111, 1'b0, 4);

      // Reset while a store is waiting: store must be dropped
      req_valid[1]  = 1'b1;
      req_we[1]     = 1'b1;
      req_funct3[1] = F_W;
      req_addr[1]   = 32'h8;
      req_wdata[1]  = 32'hCAFEF00D;
      check("mid_rst_ready_before", 32'(req_ready[1]), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid[1] = 1'b0;
      check("mid_rst_busy", 32'(req_ready[1]), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_valid", 32'(resp_valid[1]), 32'd0);
      check("mid_rst_ready", 32'(req_ready[1]), 32'd1);
      $display("txn dut1 mid_rst ready=%0d valid=%0d", req_ready[1], resp_valid[1]);
      txn(1, "w_lw8_old", 1'b0, F_W,  32'h8, 32'h0,       32'h11111111, 1'b0, 0);
      txn(1, "w_lbu_b",   1'b0, F_BU, 32'hB, 32'h0,       32'h00000011, 1'b0, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
